evt_counter_bank: RTL and testbench

Multi-channel, parametrised event counter bank for the fpgaboy fabric. It provides NUM_CH independent counters, each WIDTH bits wide. Every channel has its own runtime modulus, a counting mode (wrap, saturate, one-shot), an enable, a synchronous clear, a terminal-count pulse and a sticky done flag. It replaces single-channel, fixed-modulus event counters wherever several event streams need counting, such as UART bit/byte tallies, timer prescalers and frame/line counters.

---
 rtl/evt_counter_bank_pkg.sv | 10 +
 rtl/evt_counter_bank_if.sv | 25 ++
 rtl/evt_counter_chan.sv | 46 ++++
 rtl/evt_counter_bank.sv | 45 ++++
 tb/tb_evt_counter_bank.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/evt_counter_bank_pkg.sv
// evt_counter_pkg: counting-mode encoding shared by the event counter bank and its channels.
package evt_counter_pkg;
  localparam int MODE_W = 2;
  typedef enum logic [MODE_W-1:0] {
    CNT_WRAP    = 2'd0,
    CNT_SAT     = 2'd1,
    CNT_ONESHOT = 2'd2,
    CNT_RSVD    = 2'd3
  } cnt_mode_e;
endpackage

// File: rtl/evt_counter_bank_if.sv
// evt_counter_bank_if: per-channel control inputs and count/status/snapshot outputs of the counter bank.
interface evt_counter_bank_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16
);
  logic [NUM_CH-1:0]                         evt_in;
  logic [NUM_CH-1:0]                         en_in;
  logic [evt_counter_pkg::MODE_W*NUM_CH-1:0] mode_in;
  logic [WIDTH*NUM_CH-1:0]                   modulus_in;
  logic [NUM_CH-1:0]                         clr_in;
  logic                                      capture_in;
  logic [WIDTH*NUM_CH-1:0]                   count_out;
  logic [NUM_CH-1:0]                         tc_out;
  logic [NUM_CH-1:0]                         done_out;
  logic [WIDTH*NUM_CH-1:0]                   snap_out;
  logic                                      snap_valid_out;
  modport master (
    output evt_in, en_in, mode_in, modulus_in, clr_in, capture_in,
    input  count_out, tc_out, done_out, snap_out, snap_valid_out
  );
  modport slave (
    input  evt_in, en_in, mode_in, modulus_in, clr_in, capture_in,
    output count_out, tc_out, done_out, snap_out, snap_valid_out
  );
endinterface

// File: rtl/evt_counter_chan.sv
// evt_counter_chan: one counter channel with runtime modulus, wrap/saturate/one-shot modes, tc pulse and sticky done.
module evt_counter_chan
  import evt_counter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             evt_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  cnt_mode_e        mode_i,
  input  logic [WIDTH-1:0] modulus_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             done_o
);
  logic [WIDTH-1:0] count_q, count_d, term, inc;
  logic tc_q, tc_d, done_q, done_d, at_term, hold, active, sat_hit;
  always_comb begin
    term    = modulus_i - WIDTH'(1);
    inc     = count_q + WIDTH'(1);
    at_term = count_q >= term;
    hold    = (mode_i == CNT_SAT) || (mode_i == CNT_ONESHOT);
    active  = evt_i & en_i & ~done_q;
    // saturating modes fire on reaching term, or on the first event already sitting at/above it
    sat_hit = hold & (at_term | (inc == term));
    count_d = !active ? count_q : at_term ? (hold ? count_q : '0) : inc;
    tc_d    = active & (at_term | sat_hit);
    done_d  = done_q | (active & sat_hit);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end
  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign done_o  = done_q;
endmodule

// File: rtl/evt_counter_bank.sv
// evt_counter_bank: NUM_CH independent event counters plus a shared snapshot register.
// Snapshot logic is built only when EVT_COUNTER_BANK_SNAPSHOT_EN is defined; otherwise snap outputs are tied to 0.
module evt_counter_bank
  import evt_counter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16
) (
  input logic               clk_in,
  input logic               rst_in,
  evt_counter_bank_if.slave bus
);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    evt_counter_chan #(.WIDTH(WIDTH)) u_chan (
      .clk_i     (clk_in),
      .rst_i     (rst_in),
      .evt_i     (bus.evt_in[c]),
      .en_i      (bus.en_in[c]),
      .clr_i     (bus.clr_in[c]),
      .mode_i    (cnt_mode_e'(bus.mode_in[MODE_W*c +: MODE_W])),
      .modulus_i (bus.modulus_in[WIDTH*c +: WIDTH]),
      .count_o   (bus.count_out[WIDTH*c +: WIDTH]),
      .tc_o      (bus.tc_out[c]),
      .done_o    (bus.done_out[c])
    );
  end
`ifdef EVT_COUNTER_BANK_SNAPSHOT_EN
  logic [WIDTH*NUM_CH-1:0] snap_q;
  logic                    snap_valid_q;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      if (bus.capture_in) snap_q <= bus.count_out;
      snap_valid_q <= bus.capture_in;
    end
  end
  assign bus.snap_out       = snap_q;
  assign bus.snap_valid_out = snap_valid_q;
`else
  assign bus.snap_out       = '0;
  assign bus.snap_valid_out = 1'b0;
`endif
endmodule

// File: tb/tb_evt_counter_bank.sv
// tb_evt_counter_bank: table vectors, directed corner sequences and random traffic checked against a behavioural model.
module tb_evt_counter_bank;
  localparam int NC = 4;
  localparam int W  = 8;
  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;
  evt_counter_bank_if #(.NUM_CH(NC), .WIDTH(W)) bus ();
  evt_counter_bank #(.NUM_CH(NC), .WIDTH(W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );
  typedef struct {
    int         ch;
    logic [1:0] mode;
    logic [7:0] modv;
    logic       evt;
    logic       clr;
    logic [7:0] cnt;
    logic       tc;
    logic       done;
  } vec_t;
  vec_t tbl[$];
  int   m_cnt[NC];
  bit   m_tc[NC];
  bit   m_done[NC];
  logic [W*NC-1:0] m_snap;
  bit   m_sv;
  int   n_vec = 0;
  int   n_bad = 0;
  task automatic model_step(input int i);
    int         term;
    logic [1:0] md;
    logic [7:0] mv;
    mv   = bus.modulus_in[W*i +: W];
    md   = bus.mode_in[2*i +: 2];
    term = (mv == 0) ? 255 : int'(mv) - 1;
    m_tc[i] = 0;
    if (bus.clr_in[i]) begin
      m_cnt[i]  = 0;
      m_done[i] = 0;
    end else if (bus.evt_in[i] && bus.en_in[i] && !m_done[i]) begin
      if (md == 2'd1 || md == 2'd2) begin
        if (m_cnt[i] < term) m_cnt[i]++;
        if (m_cnt[i] >= term) begin
          m_done[i] = 1;
          m_tc[i]   = 1;
        end
      end else if (m_cnt[i] >= term) begin
        m_cnt[i] = 0;
        m_tc[i]  = 1;
      end else m_cnt[i]++;
    end
  endtask
  task automatic check(input string tag);
    logic [W*NC-1:0] ec;
    logic [NC-1:0]   et, ed;
    for (int i = 0; i < NC; i++) begin
      ec[W*i +: W] = m_cnt[i][7:0];
      et[i] = m_tc[i];
      ed[i] = m_done[i];
    end
    n_vec++;
    if (bus.count_out !== ec || bus.tc_out !== et || bus.done_out !== ed ||
        bus.snap_out !== m_snap || bus.snap_valid_out !== m_sv) begin
      n_bad++;
      $display("FAIL %s t=%0t: count=%h want %h, tc=%b want %b, done=%b want %b, snap=%h want %h, snap_valid=%b want %b",
               tag, $time, bus.count_out, ec, bus.tc_out, et, bus.done_out, ed,
               bus.snap_out, m_snap, bus.snap_valid_out, m_sv);
    end
  endtask
  task automatic tick(input string tag);
    int prev[NC];
    prev = m_cnt;
    @(posedge clk_in);
    if (rst_in) begin
      for (int i = 0; i < NC; i++) begin
        m_cnt[i]  = 0;
        m_tc[i]   = 0;
        m_done[i] = 0;
      end
      m_snap = '0;
      m_sv   = 0;
    end else begin
`ifdef EVT_COUNTER_BANK_SNAPSHOT_EN
      if (bus.capture_in) for (int i = 0; i < NC; i++) m_snap[W*i +: W] = prev[i][7:0];
      m_sv = bus.capture_in;
`endif
      for (int i = 0; i < NC; i++) model_step(i);
    end
    #1;
    check(tag);
  endtask
  task automatic expect_ch(input string tag, input int ch, input logic [7:0] cnt,
                           input logic tc, input logic done);
    n_vec++;
    if (bus.count_out[W*ch +: W] !== cnt || bus.tc_out[ch] !== tc || bus.done_out[ch] !== done) begin
      n_bad++;
      $display("FAIL %s ch%0d: count=%0d want %0d, tc=%b want %b, done=%b want %b",
               tag, ch, bus.count_out[W*ch +: W], cnt, bus.tc_out[ch], tc, bus.done_out[ch], done);
    end
  endtask
  task automatic set_ch(input int ch, input logic [1:0] mode, input logic [7:0] modv);
    bus.mode_in[2*ch +: 2]    = mode;
    bus.modulus_in[W*ch +: W] = modv;
  endtask
  task automatic clear_all();
    bus.evt_in = '0;
    bus.clr_in = '1;
    tick("clear");
    bus.clr_in = '0;
  endtask
  initial begin
    logic [7:0] ws[5] = '{8'd1, 8'd2, 8'd2, 8'd2, 8'd2};
    logic [7:0] exp_snap;
    for (int k = 1; k <= 12; k++) tbl.push_back('{0, 2'd0, 8'd5, 1'b1, 1'b0, 8'(k % 5), (k % 5) == 0, 1'b0});
    for (int k = 1; k <= 5; k++) tbl.push_back('{1, 2'd1, 8'd3, 1'b1, 1'b0, ws[k-1], k == 2, k >= 2});
    tbl.push_back('{1, 2'd1, 8'd3, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0});
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = 0;
      m_tc[i] = 0;
      m_done[i] = 0;
    end
    m_snap = '0;
    m_sv = 0;
    rst_in = 1'b1;
    bus.evt_in = '1;
    bus.en_in = '1;
    bus.clr_in = '0;
    bus.mode_in = '0;
    bus.modulus_in = '0;
    bus.capture_in = 1'b1;
    for (int k = 0; k < 10; k++) tick("reset");
    rst_in = 1'b0;
    bus.evt_in = '0;
    bus.capture_in = 1'b0;
    tick("idle");
    foreach (tbl[r]) begin
      bus.evt_in = '0;
      bus.clr_in = '0;
      set_ch(tbl[r].ch, tbl[r].mode, tbl[r].modv);
      bus.evt_in[tbl[r].ch] = tbl[r].evt;
      bus.clr_in[tbl[r].ch] = tbl[r].clr;
      tick("table");
      expect_ch("table", tbl[r].ch, tbl[r].cnt, tbl[r].tc, tbl[r].done);
    end
    set_ch(2, 2'd2, 8'd0);
    set_ch(3, 2'd0, 8'd7);
    clear_all();
    bus.evt_in = 4'b1100;
    for (int k = 0; k < 255; k++) tick("oneshot");
    expect_ch("oneshot_term", 2, 8'd255, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) tick("oneshot_halt");
    expect_ch("oneshot_held", 2, 8'd255, 1'b0, 1'b1);
    expect_ch("oneshot_nbr", 3, 8'd1, 1'b0, 1'b0);
    for (int s = 0; s < 2; s++) begin
      set_ch(0, s == 0 ? 2'd0 : 2'd1, 8'd10);
      clear_all();
      bus.evt_in = 4'b0001;
      for (int k = 0; k < 7; k++) tick("modlow_fill");
      expect_ch("modlow_seven", 0, 8'd7, 1'b0, 1'b0);
      set_ch(0, s == 0 ? 2'd0 : 2'd1, 8'd4);
      tick("modlow_step");
      if (s == 0) expect_ch("modlow_wrap", 0, 8'd0, 1'b1, 1'b0);
      else expect_ch("modlow_sat", 0, 8'd7, 1'b1, 1'b1);
    end
    set_ch(0, 2'd0, 8'd10);
    clear_all();
    bus.evt_in = 4'b0001;
    for (int k = 0; k < 3; k++) tick("snap_fill");
    bus.capture_in = 1'b1;
    tick("snap_cap");
    bus.capture_in = 1'b0;
    bus.evt_in = '0;
`ifdef EVT_COUNTER_BANK_SNAPSHOT_EN
    exp_snap = 8'd3;
`else
    exp_snap = 8'd0;
`endif
    n_vec++;
    if (bus.snap_out[7:0] !== exp_snap || bus.snap_valid_out !== (exp_snap != 0) || bus.count_out[7:0] !== 8'd4) begin
      n_bad++;
      $display("FAIL snap_ch0: snap=%0d want %0d, valid=%b, count=%0d want 4",
               bus.snap_out[7:0], exp_snap, bus.snap_valid_out, bus.count_out[7:0]);
    end
    tick("snap_after");
    n_vec++;
    if (bus.snap_valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL snap_pulse: snap_valid=%b want 0", bus.snap_valid_out);
    end
    bus.evt_in = 4'b0001;
    bus.capture_in = 1'b1;
    tick("snap_b2b");
    tick("snap_b2b");
    bus.capture_in = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (k % 20 == 0)
        for (int i = 0; i < NC; i++)
          set_ch(i, 2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9)));
      rst_in = ($urandom_range(0, 59) == 0);
      bus.evt_in = 4'($urandom);
      bus.en_in = 4'($urandom) | 4'($urandom);
      for (int i = 0; i < NC; i++) bus.clr_in[i] = ($urandom_range(0, 11) == 0);
      bus.capture_in = ($urandom_range(0, 3) == 0);
      tick("random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
